can_error_frame_gen: RTL and testbench

Transmit-side counterpart of the CAN error detection/counter logic: when a protocol error or overload condition is reported, this block generates the error or overload frame on the bus. It produces the active or passive error flag, handles superimposed flags from other nodes, and sends the error/overload delimiter. It also produces the `dominant_after_flag` and dominant-overrun pulses that the error counters consume. It sits between the error detector and the bit-stream TX mux, and all bus activity is qualified by `sample_point`.

---
 rtl/can_pkg.sv | 17 +
 rtl/can_equal_bit_counter.sv | 39 +++
 rtl/can_error_frame_gen.sv | 166 ++++++++++++++++
 tb/tb_can_error_frame_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: error/overload frame states and default frame timing constants.
package can_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT_FLAG,
        ST_PAS_FLAG,
        ST_OVL_FLAG,
        ST_WAIT_REC,
        ST_DELIM
    } err_frame_state_e;

    localparam int CAN_ERR_FLAG_LEN  = 6;
    localparam int CAN_ERR_DELIM_LEN = 8;
    localparam int CAN_DOM_LIMIT     = 8;

endpackage

// File: rtl/can_equal_bit_counter.sv
// Run-length counter of equal-polarity sampled bits; run_next is the count including the current sample.
// Updates on sample strobes only; clear has priority and restarts the run on the next sample.
module can_equal_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic             bit_in,
    output logic [CNT_W-1:0] run_next
);

    logic [CNT_W-1:0] run_len;
    logic             prev_bit;

    // A zero count marks the first sample of a run; the count saturates instead of wrapping.
    always_comb begin
        run_next = run_len;
        if (run_len == '0 || bit_in != prev_bit) begin
            run_next = CNT_W'(1);
        end else if (run_len != '1) begin
            run_next = run_len + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len  <= '0;
            prev_bit <= 1'b1;
        end else if (clear) begin
            run_len  <= '0;
        end else if (sample) begin
            run_len  <= run_next;
            prev_bit <= bit_in;
        end
    end

endmodule

// File: rtl/can_error_frame_gen.sv
// CAN error/overload frame generator: flag, superimposed-flag wait and delimiter, all on sample points.
// One clk from sample_point to tx_bit and pulses; no backpressure, bus_off forces IDLE on the next clk.
module can_error_frame_gen
    import can_pkg::*;
#(
    parameter int FLAG_LEN  = CAN_ERR_FLAG_LEN,
    parameter int DELIM_LEN = CAN_ERR_DELIM_LEN,
    parameter int DOM_LIMIT = CAN_DOM_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_point,
    input  logic rx_bit,
    input  logic error_detected,
    input  logic overload_request,
    input  logic error_passive,
    input  logic bus_off,
    output logic tx_bit,
    output logic frame_busy,
    output logic in_error_flag,
    output logic in_overload_flag,
    output logic in_delimiter,
    output logic dominant_after_flag,
    output logic dominant_overrun,
    output logic delim_form_error,
    output logic frame_done
);

    localparam int MAX_LEN = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int BW      = $clog2(MAX_LEN + 1);
    localparam int RW      = $clog2(FLAG_LEN + 1);
    localparam int DW      = (DOM_LIMIT > 2) ? $clog2(DOM_LIMIT) : 1;

    err_frame_state_e state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [DW-1:0]    dom_cnt, dom_cnt_n;
    logic             first_wait, first_wait_n;
    logic             is_err, is_err_n;
    logic             tx_n, daf_n, ovr_n, dfe_n, done_n;
    logic [RW-1:0]    run_next;

    can_equal_bit_counter #(.CNT_W(RW)) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != ST_PAS_FLAG),
        .sample   (sample_point && state == ST_PAS_FLAG),
        .bit_in   (rx_bit),
        .run_next (run_next)
    );

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        dom_cnt_n    = dom_cnt;
        first_wait_n = first_wait;
        is_err_n     = is_err;
        daf_n        = 1'b0;
        ovr_n        = 1'b0;
        dfe_n        = 1'b0;
        done_n       = 1'b0;
        if (bus_off) begin
            state_n      = ST_IDLE;
            bit_cnt_n    = '0;
            dom_cnt_n    = '0;
            first_wait_n = 1'b0;
        end else if (sample_point) begin
            unique case (state)
                ST_IDLE: begin
                    if (error_detected) begin
                        state_n   = error_passive ? ST_PAS_FLAG : ST_ACT_FLAG;
                        is_err_n  = 1'b1;
                        bit_cnt_n = '0;
                    end else if (overload_request) begin
                        state_n   = ST_OVL_FLAG;
                        is_err_n  = 1'b0;
                        bit_cnt_n = '0;
                    end
                end
                ST_ACT_FLAG, ST_OVL_FLAG: begin
                    if (bit_cnt == BW'(FLAG_LEN - 1)) begin
                        state_n      = ST_WAIT_REC;
                        bit_cnt_n    = '0;
                        dom_cnt_n    = '0;
                        first_wait_n = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
                ST_PAS_FLAG: begin
                    if (run_next == RW'(FLAG_LEN)) begin
                        state_n      = ST_WAIT_REC;
                        bit_cnt_n    = '0;
                        dom_cnt_n    = '0;
                        first_wait_n = 1'b1;
                    end
                end
                ST_WAIT_REC: begin
                    first_wait_n = 1'b0;
                    if (!rx_bit) begin
                        daf_n = first_wait && is_err;
                        if (dom_cnt == DW'(DOM_LIMIT - 1)) begin
                            dom_cnt_n = '0;
                            ovr_n     = 1'b1;
                        end else begin
                            dom_cnt_n = dom_cnt + DW'(1);
                        end
                    end else begin
                        // This recessive sample is already delimiter bit 1.
                        state_n   = ST_DELIM;
                        bit_cnt_n = BW'(1);
                    end
                end
                ST_DELIM: begin
                    if (rx_bit) begin
                        if (bit_cnt == BW'(DELIM_LEN - 1)) begin
                            state_n   = ST_IDLE;
                            bit_cnt_n = '0;
                            done_n    = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end else begin
                        state_n   = error_passive ? ST_PAS_FLAG : ST_ACT_FLAG;
                        is_err_n  = 1'b1;
                        bit_cnt_n = '0;
                        dfe_n     = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        tx_n = !(state_n == ST_ACT_FLAG || state_n == ST_OVL_FLAG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            bit_cnt             <= '0;
            dom_cnt             <= '0;
            first_wait          <= 1'b0;
            is_err              <= 1'b0;
            tx_bit              <= 1'b1;
            dominant_after_flag <= 1'b0;
            dominant_overrun    <= 1'b0;
            delim_form_error    <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            state               <= state_n;
            bit_cnt             <= bit_cnt_n;
            dom_cnt             <= dom_cnt_n;
            first_wait          <= first_wait_n;
            is_err              <= is_err_n;
            tx_bit              <= tx_n;
            dominant_after_flag <= daf_n;
            dominant_overrun    <= ovr_n;
            delim_form_error    <= dfe_n;
            frame_done          <= done_n;
        end
    end

    assign frame_busy       = (state != ST_IDLE);
    assign in_error_flag    = (state == ST_ACT_FLAG) || (state == ST_PAS_FLAG);
    assign in_overload_flag = (state == ST_OVL_FLAG);
    assign in_delimiter     = (state == ST_DELIM);

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Bench for can_error_frame_gen: directed frame scenarios plus random bit streams against a bit-level model.
module tb_can_error_frame_gen;

    localparam int FL = can_pkg::CAN_ERR_FLAG_LEN;
    localparam int DL = can_pkg::CAN_ERR_DELIM_LEN;
    localparam int DM = can_pkg::CAN_DOM_LIMIT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample_point = 1'b0, rx_bit = 1'b1, error_detected = 1'b0, overload_request = 1'b0;
    logic error_passive = 1'b0, bus_off = 1'b0;
    logic tx_bit, frame_busy, in_error_flag, in_overload_flag, in_delimiter;
    logic dominant_after_flag, dominant_overrun, delim_form_error, frame_done;

    can_error_frame_gen #(.FLAG_LEN(FL), .DELIM_LEN(DL), .DOM_LIMIT(DM)) dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
        .error_detected(error_detected), .overload_request(overload_request),
        .error_passive(error_passive), .bus_off(bus_off), .tx_bit(tx_bit),
        .frame_busy(frame_busy), .in_error_flag(in_error_flag),
        .in_overload_flag(in_overload_flag), .in_delimiter(in_delimiter),
        .dominant_after_flag(dominant_after_flag), .dominant_overrun(dominant_overrun),
        .delim_form_error(delim_form_error), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    wire [4:0] obs_st = {tx_bit, frame_busy, in_error_flag, in_overload_flag, in_delimiter};
    wire [3:0] obs_pl = {dominant_after_flag, dominant_overrun, delim_form_error, frame_done};

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_daf = 0, cnt_ovr = 0, cnt_dfe = 0, cnt_done = 0;
    bit last_done;

    // Reference model: the frame as a sequence of bit phases, with the flag bits kept in a queue.
    string phase = "idle";
    bit    m_is_err;
    bit    flag_q[$];
    int    dom_seen, delim_cnt;
    logic [4:0] exp_st = 5'b10000;
    logic [3:0] exp_pl = 4'b0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_flag(input bit ep);
        phase    = ep ? "pflag" : "aflag";
        m_is_err = 1'b1;
        flag_q.delete();
    endtask

    task automatic model_reset();
        phase = "idle";
        flag_q.delete();
        exp_pl = 4'b0000;
        exp_st = 5'b10000;
    endtask

    task automatic model_sample(input bit rx, input bit err, input bit ovl, input bit ep, input bit boff);
        bit all_eq;
        exp_pl = 4'b0000;
        if (boff) begin
            phase = "idle";
        end else begin
            case (phase)
                "idle": begin
                    if (err) start_flag(ep);
                    else if (ovl) begin phase = "oflag"; m_is_err = 1'b0; flag_q.delete(); end
                end
                "aflag", "oflag": begin
                    flag_q.push_back(rx);
                    if (flag_q.size() == FL) begin phase = "wait"; dom_seen = 0; end
                end
                "pflag": begin
                    flag_q.push_back(rx);
                    if (flag_q.size() >= FL) begin
                        all_eq = 1'b1;
                        for (int i = flag_q.size() - FL; i < flag_q.size(); i++)
                            if (flag_q[i] != rx) all_eq = 1'b0;
                        if (all_eq) begin phase = "wait"; dom_seen = 0; end
                    end
                end
                "wait": begin
                    if (!rx) begin
                        dom_seen++;
                        if (dom_seen == 1 && m_is_err) exp_pl[3] = 1'b1;
                        if (dom_seen % DM == 0) exp_pl[2] = 1'b1;
                    end else begin
                        phase = "delim";
                        delim_cnt = 1;
                    end
                end
                "delim": begin
                    if (rx) begin
                        delim_cnt++;
                        if (delim_cnt == DL) begin exp_pl[0] = 1'b1; phase = "idle"; end
                    end else begin
                        exp_pl[1] = 1'b1;
                        start_flag(ep);
                    end
                end
                default: phase = "idle";
            endcase
        end
        exp_st = {!(phase == "aflag" || phase == "oflag"), phase != "idle",
                  phase == "aflag" || phase == "pflag", phase == "oflag", phase == "delim"};
    endtask

    // One bit time: sample cycle, then a check cycle, then a cycle where pulses must be gone.
    task automatic do_bit(input bit rx, input bit err, input bit ovl, input bit ep, input bit boff);
        @(negedge clk);
        sample_point = 1'b1; rx_bit = rx; error_detected = err;
        overload_request = ovl; error_passive = ep; bus_off = boff;
        model_sample(rx, err, ovl, ep, boff);
        @(negedge clk);
        sample_point = 1'b0; error_detected = 1'b0; overload_request = 1'b0;
        chk("status", 32'(obs_st), 32'(exp_st));
        chk("pulse", 32'(obs_pl), 32'(exp_pl));
        last_done = frame_done;
        cnt_daf  += int'(dominant_after_flag);
        cnt_ovr  += int'(dominant_overrun);
        cnt_dfe  += int'(delim_form_error);
        cnt_done += int'(frame_done);
        @(negedge clk);
        chk("pulse_clr", 32'(obs_pl), 32'd0);
    endtask

    // Bits after the trigger: the first 'zeros' dominant, rest recessive; lat = bit index of frame_done.
    task automatic run_until_done(input int zeros, input int max_bits, input bit ep, output int lat);
        lat = -1;
        for (int i = 1; i <= max_bits; i++) begin
            do_bit(i <= zeros ? 1'b0 : 1'b1, 1'b0, 1'b0, ep, 1'b0);
            if (last_done) begin lat = i; break; end
        end
    endtask

    int lat, d0, o0, e0, n0, pas_len;
    bit tx_low;

    initial begin
        #2 rst = 1'b1;
        #1 chk("rst_status", 32'(obs_st), 32'h10);
        chk("rst_pulse", 32'(obs_pl), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Active error, clean bus.
        d0 = cnt_daf;
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until_done(FL, 30, 1'b0, lat);
        chk("lat_active", 32'(lat), 32'(FL + DL));
        chk("daf_clean", 32'(cnt_daf - d0), 32'd0);

        // Superimposed flag: three extra dominant bits.
        d0 = cnt_daf; o0 = cnt_ovr;
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until_done(FL + 3, 30, 1'b0, lat);
        chk("lat_super", 32'(lat), 32'(FL + 3 + DL));
        chk("daf_super", 32'(cnt_daf - d0), 32'd1);
        chk("ovr_super", 32'(cnt_ovr - o0), 32'd0);

        // Sixteen dominant bits after our flag.
        o0 = cnt_ovr;
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until_done(FL + 16, 40, 1'b0, lat);
        chk("ovr_16", 32'(cnt_ovr - o0), 32'd2);
        chk("lat_16", 32'(lat), 32'(FL + 16 + DL));

        // Passive flag: rx 1,0,0,0,0,0,0 then recessive.
        pas_len = -1; tx_low = 1'b0;
        do_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            do_bit(i >= 2 && i <= 7 ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (!tx_bit) tx_low = 1'b1;
            if (!in_error_flag && pas_len < 0) pas_len = i;
        end
        chk("pas_len", 32'(pas_len), 32'd7);
        chk("pas_tx", 32'(tx_low), 32'd0);

        // Dominant at delimiter bit 4 restarts an active flag.
        e0 = cnt_dfe; n0 = cnt_done; lat = -1;
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            do_bit((i <= FL) || (i == FL + 4) || (i > FL + 4 && i <= 2 * FL + 4) ? 1'b0 : 1'b1,
                   1'b0, 1'b0, 1'b0, 1'b0);
            if (last_done) begin lat = i; break; end
        end
        chk("dfe_cnt", 32'(cnt_dfe - e0), 32'd1);
        chk("lat_dfe", 32'(lat), 32'(2 * FL + 4 + DL));

        // Error and overload together: error wins.
        do_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_ovl", 32'(in_overload_flag), 32'd0);
        chk("both_err", 32'(in_error_flag), 32'd1);
        run_until_done(FL, 30, 1'b0, lat);

        // bus_off between sample points in the middle of a flag.
        n0 = cnt_done;
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); bus_off = 1'b1;
        @(negedge clk);
        chk("boff_status", 32'(obs_st), 32'h10);
        chk("boff_pulse", 32'(obs_pl), 32'd0);
        model_reset();
        do_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        do_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("boff_done", 32'(cnt_done - n0), 32'd0);

        // Reset in the middle of the delimiter.
        do_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= FL + 3; i++) do_bit(i <= FL ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_delim", 32'(in_delimiter), 32'd1);
        @(negedge clk); rst = 1'b1;
        #1 chk("mid_rst_status", 32'(obs_st), 32'h10);
        chk("mid_rst_pulse", 32'(obs_pl), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();

        // Random bit streams.
        for (int n = 0; n < 1500; n++) begin
            bit rx, err, ovl, ep, boff;
            if (phase == "pflag" || phase == "aflag" || phase == "oflag")
                rx = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            else
                rx = ($urandom_range(0, 6) != 0);
            err  = ($urandom_range(0, 7) == 0);
            ovl  = ($urandom_range(0, 9) == 0);
            ep   = ($urandom_range(0, 2) == 0);
            boff = ($urandom_range(0, 149) == 0);
            do_bit(rx, err, ovl, ep, boff);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
